bcd_display_sequencer: RTL and testbench
========================================

Name: bcd_display_sequencer

Overview:
Consumer end of the clkscaler strobe interface. Holds a DIGITS-wide BCD counter value. Each inc_strobe adds a trigger-selected BCD increment to the counter; each ref_strobe snapshots the value and serially transmits it to a MAX7219-style 7-segment driver over a write-only SPI link. Sits between clkscaler and the chip pads; after reset it first sends the display-driver initialisation sequence.

Parameters:
DIGITS, 8, number of BCD digits held and displayed (1..8).
CLK_DIV, 4, clk cycles per SCLK half-period (>=1); one bit slot is 2*CLK_DIV cycles.
INTENSITY, 4'h7, brightness value sent in the init sequence.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
trigger  input  DIGITS  digit-select mask; sampled only in the cycle inc_strobe is high.
inc_strobe  input  1  one-cycle increment pulse (clkscaler inc_clk).
ref_strobe  input  1  one-cycle refresh pulse (clkscaler ref_clk).
digits  output  4*DIGITS  current BCD value; digit i is bits [4i+3:4i].
spi_cs_n  output  1  chip select, active low.
spi_sclk  output  1  serial clock, idle low.
spi_mosi  output  1  serial data, MSB first.
busy  output  1  high while any frame sequence (init or refresh) is in progress or pending.

Behaviour:
- Reset (asynchronous) values: digits=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=1 (init pending), refresh pending flag cleared.
- Increment:
  - On inc_strobe, digits <= digits + M, where M is the BCD number with digit i = trigger[i].
  - Per-digit ripple: sum = d_i + trigger[i] + carry_in. If sum >= 10, the digit becomes sum-10 and carries out.
  - Carry out of the top digit is discarded, so the value wraps mod 10^DIGITS.
  - Applied in the same cycle, independent of the SPI state.
  - trigger==0 with inc_strobe produces no change.
- Frame format: 16 bits, {4'h0, addr[3:0], data[7:0]}, MSB first.
- SPI timing, one frame:
  - spi_cs_n goes low, followed by 16 bit slots.
  - In slot b (b=0..15), spi_mosi = frame[15-b] for the whole slot. spi_sclk is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
  - After slot 15, spi_sclk=0 and spi_cs_n=1 for a gap of 2*CLK_DIV cycles before the next frame or IDLE.
  - Frame period = 34*CLK_DIV cycles. spi_mosi=0 whenever spi_cs_n=1.
- Init sequence (4 frames, in order): 0x09FF (BCD decode all digits), {0x0A, 4'h0, INTENSITY}, {0x0B, DIGITS-1} (scan limit), 0x0C01 (normal operation).
- Refresh sequence (DIGITS frames), k = 1..DIGITS in order: addr=k, data={4'h0, snapshot digit k-1}.
  - Snapshot is taken when the sequence starts.
  - If inc_strobe and ref_strobe coincide, the snapshot holds the post-increment value.
  - Increments during transmission do not alter the frames in flight.
- State machine: INIT -> LOAD -> SHIFT -> GAP -> (LOAD next frame | IDLE).
  - INIT selects the init frame list and is entered only from reset.
  - IDLE: if the refresh pending flag is set or ref_strobe is high, clear the pending flag, snapshot, select the refresh list, and go to LOAD.
  - LOAD: drive spi_cs_n low and present bit 15, lasting one cycle. That cycle counts as the first cycle of slot 0.
  - SHIFT: run 16 slots with a bit counter and a divider counter.
  - GAP: inter-frame gap, then increment the frame index; after the last frame go to IDLE.
- Pending refresh:
  - ref_strobe while not in IDLE (including during init) sets a single pending flag.
  - Multiple ref_strobes while busy collapse into one refresh.
  - The pending refresh starts on the first IDLE cycle.
- busy is low only in IDLE with no pending flag and no ref_strobe this cycle.
- Reset mid-frame: all outputs return to reset values immediately, the partial frame is abandoned, digits clear, and the init sequence restarts after reset deasserts.

Test Plan:
1. Release reset, CLK_DIV=4, DIGITS=8 -> four frames decoded 0x09FF, 0x0A07, 0x0B07, 0x0C01; each frame is 136 cycles; busy falls after the last gap.
2. digits=0, inc_strobe with trigger=8'h01 three times -> digits=32'h00000003; trigger=8'h11 once more -> 32'h00010004.
3. digits=32'h00000999, trigger=8'h01 -> 32'h00001000; digits=32'h99999999, trigger=8'h01 -> 32'h00000000 (wrap).
4. digits=32'h12345678, ref_strobe in IDLE -> frames 0x0108, 0x0207, 0x0306, 0x0405, 0x0504, 0x0603, 0x0702, 0x0801; SCLK idle low; MOSI stable while SCLK high.
5. ref_strobe three times during init plus inc_strobe (trigger=8'h01) mid-refresh -> exactly one refresh after init; frames carry the snapshot value, not the mid-transfer increment.
6. Assert reset during slot 7 of a refresh frame -> spi_cs_n=1, spi_sclk=0, spi_mosi=0, digits=0 in the same cycle; after release, the init sequence restarts from 0x09FF.

Source files
------------

// File: rtl/bcd_display_sequencer_if.sv
// Strobe/trigger inputs from clkscaler plus the BCD value, SPI link and busy flag of the sequencer.
interface bcd_display_sequencer_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0]   trigger;
  logic                inc_strobe;
  logic                ref_strobe;
  logic [4*DIGITS-1:0] digits;
  logic                spi_cs_n;
  logic                spi_sclk;
  logic                spi_mosi;
  logic                busy;

  modport master (
    output trigger, inc_strobe, ref_strobe,
    input  digits, spi_cs_n, spi_sclk, spi_mosi, busy
  );

  modport slave (
    input  trigger, inc_strobe, ref_strobe,
    output digits, spi_cs_n, spi_sclk, spi_mosi, busy
  );
endinterface

// File: rtl/bcd_display_sequencer.sv
// BCD counter bumped by inc_strobe, serialised to a MAX7219-style driver over write-only SPI.
// After reset the four driver init frames go out first, then one refresh burst per request.
module bcd_display_sequencer #(
  parameter int       DIGITS    = 8,
  parameter int       CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h7
) (
  input  logic clk,
  input  logic reset,
  bcd_display_sequencer_if.slave bus
);

  localparam int SLOT = 2 * CLK_DIV;
  localparam int CW   = $clog2(SLOT + 1);

  typedef enum logic [2:0] {INIT, LOAD, SHIFT, GAP, IDLE} state_t;

  state_t              state, next_state;
  logic [4*DIGITS-1:0] digits_q, digits_next, inc_val;
  logic [4*DIGITS-1:0] snap, next_snap;
  logic                pending, next_pending;
  logic                is_refresh, next_is_refresh;
  logic [3:0]          frame_idx, next_frame_idx;
  logic [3:0]          bit_idx, next_bit_idx;
  logic [CW-1:0]       cnt, next_cnt;
  logic [15:0]         frame;
  logic [3:0]          digit_sel;
  logic [4:0]          sum;
  logic                carry;
  logic                last_frame;
  logic                cs_n, sclk, mosi;

  // Ripple BCD add of the 0/1-per-digit trigger mask; top carry is dropped.
  always_comb begin
    carry   = 1'b0;
    sum     = '0;
    inc_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sum = {1'b0, digits_q[4*i +: 4]} + {4'b0, bus.trigger[i]} + {4'b0, carry};
      if (sum >= 5'd10) begin
        inc_val[4*i +: 4] = sum[3:0] - 4'd10;
        carry             = 1'b1;
      end else begin
        inc_val[4*i +: 4] = sum[3:0];
        carry             = 1'b0;
      end
    end
    digits_next = bus.inc_strobe ? inc_val : digits_q;
  end

  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (frame_idx == 4'(i)) digit_sel = snap[4*i +: 4];
    end
    frame = 16'h0000;
    if (is_refresh) begin
      frame = {4'h0, frame_idx + 4'd1, 4'h0, digit_sel};
    end else begin
      case (frame_idx)
        4'd0:    frame = 16'h09FF;
        4'd1:    frame = {8'h0A, 4'h0, INTENSITY};
        4'd2:    frame = {8'h0B, 8'(DIGITS - 1)};
        default: frame = 16'h0C01;
      endcase
    end
    last_frame = (frame_idx == (is_refresh ? 4'(DIGITS - 1) : 4'd3));
  end

  always_comb begin
    next_state      = state;
    next_snap       = snap;
    next_pending    = pending | (bus.ref_strobe && (state != IDLE));
    next_is_refresh = is_refresh;
    next_frame_idx  = frame_idx;
    next_bit_idx    = bit_idx;
    next_cnt        = cnt;
    cs_n            = 1'b1;
    sclk            = 1'b0;
    mosi            = 1'b0;
    case (state)
      INIT: begin
        next_is_refresh = 1'b0;
        next_frame_idx  = '0;
        next_cnt        = '0;
        next_state      = LOAD;
      end
      IDLE: begin
        if (pending || bus.ref_strobe) begin
          next_pending    = 1'b0;
          next_snap       = digits_next;
          next_is_refresh = 1'b1;
          next_frame_idx  = '0;
          next_cnt        = '0;
          next_state      = LOAD;
        end
      end
      // LOAD is the first cycle of slot 0, so SHIFT resumes that slot at count 1.
      LOAD: begin
        cs_n         = 1'b0;
        mosi         = frame[15];
        next_bit_idx = '0;
        next_cnt     = CW'(1);
        next_state   = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        sclk = (cnt >= CW'(CLK_DIV));
        mosi = frame[4'd15 - bit_idx];
        if (cnt == CW'(SLOT - 1)) begin
          next_cnt = '0;
          if (bit_idx == 4'd15) next_state = GAP;
          else                  next_bit_idx = bit_idx + 4'd1;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(SLOT - 1)) begin
          next_cnt       = '0;
          next_frame_idx = frame_idx + 4'd1;
          next_state     = last_frame ? IDLE : LOAD;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      digits_q   <= '0;
      snap       <= '0;
      pending    <= 1'b0;
      is_refresh <= 1'b0;
      frame_idx  <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
    end else begin
      state      <= next_state;
      digits_q   <= digits_next;
      snap       <= next_snap;
      pending    <= next_pending;
      is_refresh <= next_is_refresh;
      frame_idx  <= next_frame_idx;
      bit_idx    <= next_bit_idx;
      cnt        <= next_cnt;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.spi_cs_n = cs_n;
  assign bus.spi_sclk = sclk;
  assign bus.spi_mosi = mosi;
  assign bus.busy     = !((state == IDLE) && !pending && !bus.ref_strobe);

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed bench for bcd_display_sequencer: an SPI monitor decodes frames, expectations are hand-computed.
module tb_bcd_display_sequencer;

  localparam int DIGITS       = 8;
  localparam int CLK_DIV      = 4;
  localparam int FRAME_CYCLES = 34 * CLK_DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_display_sequencer_if #(.DIGITS(DIGITS)) bus();

  bcd_display_sequencer #(
    .DIGITS(DIGITS),
    .CLK_DIV(CLK_DIV),
    .INTENSITY(4'h7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int idle_cycle = 0;

  logic [15:0] frames[$];
  int          starts[$];
  logic [15:0] shreg = '0;
  int          nbits = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int          stable_err = 0, idle_err = 0;

  logic [15:0] init_frames [4] = '{16'h09FF, 16'h0A07, 16'h0B07, 16'h0C01};
  logic [15:0] ref_frames  [8] = '{16'h0108, 16'h0207, 16'h0306, 16'h0405,
                                   16'h0504, 16'h0603, 16'h0702, 16'h0801};
  logic [15:0] snap_frames [8] = '{16'h0101, 16'h0200, 16'h0301, 16'h0400,
                                   16'h0500, 16'h0600, 16'h0700, 16'h0800};
  logic [7:0]  build_masks [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

  always @(posedge clk) cycle <= cycle + 1;

  // Samples the link once per cycle; a frame counts only if it completed all 16 SCLK rises.
  always @(negedge clk) begin
    if (prev_cs && !bus.spi_cs_n) begin
      starts.push_back(cycle);
      nbits = 0;
    end
    if (!bus.spi_cs_n && !prev_sclk && bus.spi_sclk) begin
      shreg = {shreg[14:0], bus.spi_mosi};
      nbits++;
    end
    if (!bus.spi_cs_n && prev_sclk && bus.spi_sclk && (bus.spi_mosi !== prev_mosi)) stable_err++;
    if (!prev_cs && bus.spi_cs_n && nbits == 16) frames.push_back(shreg);
    if (bus.spi_cs_n && (bus.spi_sclk !== 1'b0 || bus.spi_mosi !== 1'b0)) idle_err++;
    prev_cs   = bus.spi_cs_n;
    prev_sclk = bus.spi_sclk;
    prev_mosi = bus.spi_mosi;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic refr, input logic [7:0] trig);
    @(negedge clk);
    bus.inc_strobe = inc;
    bus.ref_strobe = refr;
    bus.trigger    = trig;
    @(negedge clk);
    bus.inc_strobe = 1'b0;
    bus.ref_strobe = 1'b0;
    bus.trigger    = '0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    idle_cycle = cycle;
    checkOutput("idle_wait", 32'(bus.busy), 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frames.delete();
    starts.delete();
  endtask

  function automatic logic [31:0] frameAt(input int idx);
    return (idx < frames.size()) ? {16'h0, frames[idx]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got time %0t, expected finish before 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.trigger    = '0;
    bus.inc_strobe = 1'b0;
    bus.ref_strobe = 1'b0;

    // Reset state and init sequence
    @(negedge clk);
    checkOutput("reset_cs_n",   32'(bus.spi_cs_n), 32'h1);
    checkOutput("reset_sclk",   32'(bus.spi_sclk), 32'h0);
    checkOutput("reset_mosi",   32'(bus.spi_mosi), 32'h0);
    checkOutput("reset_busy",   32'(bus.busy),     32'h1);
    checkOutput("reset_digits", bus.digits,        32'h0);
    reset = 1'b0;
    waitIdle(1000);
    checkOutput("init_count", 32'(frames.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("init_frame%0d", i), frameAt(i), {16'h0, init_frames[i]});
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("init_period%0d", i),
                  (starts.size() > i) ? 32'(starts[i] - starts[i-1]) : 32'hFFFF_FFFF, 32'(FRAME_CYCLES));
    checkOutput("busy_fall", (starts.size() == 4) ? 32'(idle_cycle - starts[3]) : 32'hFFFF_FFFF,
                32'(FRAME_CYCLES));

    // Plain increments
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h01);
    checkOutput("inc_three", bus.digits, 32'h0000_0003);
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkOutput("inc_mask11", bus.digits, 32'h0001_0004);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("inc_zero", bus.digits, 32'h0001_0004);

    // Carry ripple and wrap
    doReset();
    waitIdle(1000);
    repeat (9) applyStimulus(1'b1, 1'b0, 8'h07);
    checkOutput("build_999", bus.digits, 32'h0000_0999);
    applyStimulus(1'b1, 1'b0, 8'h01);
    checkOutput("carry_1000", bus.digits, 32'h0000_1000);
    doReset();
    waitIdle(1000);
    repeat (9) applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("build_all9", bus.digits, 32'h9999_9999);
    applyStimulus(1'b1, 1'b0, 8'h01);
    checkOutput("wrap_zero", bus.digits, 32'h0000_0000);

    // Refresh of 12345678 from IDLE
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, build_masks[i]);
    checkOutput("build_12345678", bus.digits, 32'h1234_5678);
    frames.delete();
    starts.delete();
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitIdle(2000);
    checkOutput("ref_count", 32'(frames.size()), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("ref_frame%0d", i), frameAt(i), {16'h0, ref_frames[i]});

    // Requests during init collapse into one refresh carrying the snapshot
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h00);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h05);
    repeat (100) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'h00);
    n = 0;
    while (frames.size() < 6 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_refresh_reached", 32'(frames.size()), 32'd6);
    applyStimulus(1'b1, 1'b0, 8'h01);
    waitIdle(3000);
    checkOutput("pend_count", 32'(frames.size()), 32'd12);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("snap_frame%0d", i), frameAt(i + 4), {16'h0, snap_frames[i]});
    checkOutput("post_inc_digits", bus.digits, 32'h0000_0102);
    repeat (300) @(negedge clk);
    checkOutput("no_extra_frames", 32'(frames.size()), 32'd12);
    checkOutput("still_idle", 32'(bus.busy), 32'h0);

    // Reset in slot 7 of the first refresh frame (0x0102, bit 8 is a one)
    applyStimulus(1'b0, 1'b1, 8'h00);
    n = 0;
    while (bus.spi_cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_started", 32'(bus.spi_cs_n), 32'h0);
    repeat (58) @(negedge clk);
    checkOutput("slot7_mosi", 32'(bus.spi_mosi), 32'h1);
    checkOutput("slot7_sclk", 32'(bus.spi_sclk), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_cs_n",   32'(bus.spi_cs_n), 32'h1);
    checkOutput("midrst_sclk",   32'(bus.spi_sclk), 32'h0);
    checkOutput("midrst_mosi",   32'(bus.spi_mosi), 32'h0);
    checkOutput("midrst_digits", bus.digits,        32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frames.delete();
    starts.delete();
    waitIdle(1000);
    checkOutput("reinit_count", 32'(frames.size()), 32'd4);
    checkOutput("reinit_first", frameAt(0), 32'h0000_09FF);

    checkOutput("mosi_stable", 32'(stable_err), 32'h0);
    checkOutput("idle_lines",  32'(idle_err),   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
